// File: rtl/mmio_host_requester.sv
// rtl/mmio_host_requester.sv - CCI-P MMIO host requester; optional statistics counters under MMIO_REQ_STATS_EN
module mmio_host_requester #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int TID_W          = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_wr,
   input  logic [15:0]      cmd_addr,
   input  logic [63:0]      cmd_wdata,
   output logic             mmio_rd_valid,
   output logic             mmio_wr_valid,
   output logic [15:0]      mmio_addr,
   output logic [TID_W-1:0] mmio_tid,
   output logic [63:0]      mmio_wdata,
   input  logic             rsp_valid,
   input  logic [TID_W-1:0] rsp_tid,
   input  logic [63:0]      rsp_data,
   output logic             done_valid,
   output logic [63:0]      done_rdata,
   output logic [1:0]       done_err
`ifdef MMIO_REQ_STATS_EN
   ,
   output logic [31:0]      stat_rd_cnt,
   output logic [31:0]      stat_wr_cnt,
   output logic [15:0]      stat_tmo_cnt,
   output logic [15:0]      stat_stale_cnt
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_TMO   = 2'b01;
   localparam logic [1:0] ERR_ALIGN = 2'b10;

   // One extra bit so the timer can hold TIMEOUT_CYCLES itself on the exit cycle.
   localparam int             TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]       state;
   logic [TID_W-1:0] tid_cnt;
   logic [TMR_W-1:0] timer;
   logic             is_rd;

   logic             issue_go;
   logic             align_err;
   logic             rsp_match;
   logic             timed_out;

   assign cmd_ready = (state == ST_IDLE);
   assign issue_go  = cmd_ready && cmd_valid && !cmd_addr[0];
   assign align_err = cmd_ready && cmd_valid &&  cmd_addr[0];
   // mmio_tid holds the tid of the outstanding read, so it doubles as the match key.
   assign rsp_match = (state == ST_WAIT) && rsp_valid && (rsp_tid == mmio_tid);
   // A matching response in the last timer cycle wins over the timeout.
   assign timed_out = (state == ST_WAIT) && !rsp_match && (timer == TMR_LAST);

   // Command sequencing: IDLE -> ISSUE -> (WAIT_RSP) -> DONE -> IDLE, misaligned skips to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (align_err)
                  state <= ST_DONE;
               else if (issue_go)
                  state <= ST_ISSUE;
            end
            ST_ISSUE: state <= is_rd ? ST_WAIT : ST_DONE;
            ST_WAIT: begin
               if (rsp_match || timed_out)
                  state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Request fields latched on accept; pulses last exactly the ISSUE cycle; tid advances per issue
   always_ff @(posedge clk) begin
      if (rst) begin
         mmio_rd_valid <= 1'b0;
         mmio_wr_valid <= 1'b0;
         mmio_addr     <= '0;
         mmio_tid      <= '0;
         mmio_wdata    <= '0;
         tid_cnt       <= '0;
         is_rd         <= 1'b0;
      end else begin
         mmio_rd_valid <= issue_go && !cmd_wr;
         mmio_wr_valid <= issue_go &&  cmd_wr;
         if (issue_go) begin
            mmio_addr  <= cmd_addr;
            mmio_tid   <= tid_cnt;
            mmio_wdata <= cmd_wdata;
            is_rd      <= !cmd_wr;
            tid_cnt    <= tid_cnt + TID_W'(1);
         end
      end
   end

   // Response timer: zero outside WAIT_RSP so it starts at 0 on entry
   always_ff @(posedge clk) begin
      if (rst || (state != ST_WAIT))
         timer <= '0;
      else
         timer <= timer + TMR_W'(1);
   end

   // Completion pulse with data/status, cleared again on the following cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         done_valid <= 1'b0;
         done_rdata <= '0;
         done_err   <= ERR_OK;
      end else begin
         done_valid <= align_err || ((state == ST_ISSUE) && !is_rd) || rsp_match || timed_out;
         done_rdata <= rsp_match ? rsp_data : 64'd0;
         if (align_err)
            done_err <= ERR_ALIGN;
         else if (timed_out)
            done_err <= ERR_TMO;
         else
            done_err <= ERR_OK;
      end
   end

`ifdef MMIO_REQ_STATS_EN
   logic rd_evt;
   logic wr_evt;
   logic stale_evt;

   assign rd_evt    = issue_go && !cmd_wr;
   assign wr_evt    = issue_go &&  cmd_wr;
   // Any response that does not complete the outstanding read was ignored.
   assign stale_evt = rsp_valid && !rsp_match;

   // Saturating activity counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_rd_cnt    <= '0;
         stat_wr_cnt    <= '0;
         stat_tmo_cnt   <= '0;
         stat_stale_cnt <= '0;
      end else begin
         if (rd_evt && (stat_rd_cnt != '1))
            stat_rd_cnt <= stat_rd_cnt + 32'd1;
         if (wr_evt && (stat_wr_cnt != '1))
            stat_wr_cnt <= stat_wr_cnt + 32'd1;
         if (timed_out && (stat_tmo_cnt != '1))
            stat_tmo_cnt <= stat_tmo_cnt + 16'd1;
         if (stale_evt && (stat_stale_cnt != '1))
            stat_stale_cnt <= stat_stale_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mmio_host_requester.sv
// tb/tb_mmio_host_requester.sv - directed self-checking bench for mmio_host_requester
module tb_mmio_host_requester;

   localparam int T     = 16;
   localparam int TID_W = 9;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic             cmd_wr = 1'b0;
   logic [15:0]      cmd_addr = '0;
   logic [63:0]      cmd_wdata = '0;
   logic             mmio_rd_valid;
   logic             mmio_wr_valid;
   logic [15:0]      mmio_addr;
   logic [TID_W-1:0] mmio_tid;
   logic [63:0]      mmio_wdata;
   logic             rsp_valid = 1'b0;
   logic [TID_W-1:0] rsp_tid = '0;
   logic [63:0]      rsp_data = '0;
   logic             done_valid;
   logic [63:0]      done_rdata;
   logic [1:0]       done_err;
`ifdef MMIO_REQ_STATS_EN
   logic [31:0]      stat_rd_cnt;
   logic [31:0]      stat_wr_cnt;
   logic [15:0]      stat_tmo_cnt;
   logic [15:0]      stat_stale_cnt;
`endif

   mmio_host_requester #(.TIMEOUT_CYCLES(T), .TID_W(TID_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
      .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
      .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
      .done_valid(done_valid), .done_rdata(done_rdata), .done_err(done_err)
`ifdef MMIO_REQ_STATS_EN
      ,
      .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt),
      .stat_tmo_cnt(stat_tmo_cnt), .stat_stale_cnt(stat_stale_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          c;
      bit          rd;
      logic [15:0] addr;
      logic [8:0]  tid;
      logic [63:0] wdata;
   } req_t;

   typedef struct {
      int          c;
      logic [63:0] rdata;
      logic [1:0]  err;
   } done_t;

   req_t  exp_req[$];
   done_t exp_done[$];

   int busy_from = -1;
   int busy_to   = -2;
   bit checking  = 1'b0;
   int total = 0;
   int bad   = 0;

   int m_tid   = 0;
   int m_rd    = 0;
   int m_wr    = 0;
   int m_tmo   = 0;
   int m_stale = 0;

   int          last_req_c  = -1;
   logic [8:0]  last_req_tid = '0;
   int          last_done_c = -1;
   logic [63:0] last_done_rdata = '0;
   logic [1:0]  last_done_err = '0;

   bit er, ew, ed;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Per-cycle comparison against the expected event schedule
   always @(negedge clk) begin
      if (checking) begin
         er = (exp_req.size() > 0) && (exp_req[0].c == cyc) &&  exp_req[0].rd;
         ew = (exp_req.size() > 0) && (exp_req[0].c == cyc) && !exp_req[0].rd;
         ed = (exp_done.size() > 0) && (exp_done[0].c == cyc);
         chk("cmd_ready", cmd_ready, !((cyc >= busy_from) && (cyc <= busy_to)));
         chk("rd_pulse", mmio_rd_valid, er);
         chk("wr_pulse", mmio_wr_valid, ew);
         if (er || ew) begin
            chk("req_addr", mmio_addr, exp_req[0].addr);
            chk("req_tid", mmio_tid, exp_req[0].tid);
            if (ew) chk("req_wdata", mmio_wdata, exp_req[0].wdata);
            void'(exp_req.pop_front());
         end
         if (mmio_rd_valid || mmio_wr_valid) begin
            last_req_c   = cyc;
            last_req_tid = mmio_tid;
         end
         chk("done_valid", done_valid, ed);
         if (ed) begin
            chk("done_rdata", done_rdata, exp_done[0].rdata);
            chk("done_err", done_err, exp_done[0].err);
            void'(exp_done.pop_front());
         end else begin
            chk("done_rdata_idle", done_rdata, 64'd0);
            chk("done_err_idle", done_err, 2'b00);
         end
         if (done_valid) begin
            last_done_c     = cyc;
            last_done_rdata = done_rdata;
            last_done_err   = done_err;
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      rsp_valid = 1'b0;
      exp_req.delete();
      exp_done.delete();
      m_tid = 0; m_rd = 0; m_wr = 0; m_tmo = 0; m_stale = 0;
      if (busy_to > cyc) busy_to = cyc;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Issue one command from IDLE; offsets are cycles after the request (ISSUE) cycle, -1 = none
   task automatic run_cmd(input bit wr, input logic [15:0] addr, input logic [63:0] wdata,
                          input int stale_at, input logic [8:0] stale_tid,
                          input int rsp_at, input logic [63:0] rdata,
                          input int abort_at, output int acc);
      int r, dc;
      logic [8:0] tid;
      bit matched;
      tid = '0;
      matched = 1'b0;
      acc = cyc;
      r = acc + 1;
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
      if (addr[0]) begin
         dc = acc + 1;
         exp_done.push_back('{dc, 64'd0, 2'b10});
      end else begin
         tid = 9'(m_tid);
         m_tid = (m_tid + 1) % 512;
         exp_req.push_back('{r, !wr, addr, tid, wdata});
         if (wr) begin
            m_wr++;
            dc = acc + 2;
            exp_done.push_back('{dc, 64'd0, 2'b00});
         end else begin
            m_rd++;
            matched = (rsp_at >= 1) && (rsp_at <= T);
            if (matched) begin
               dc = r + rsp_at + 1;
               exp_done.push_back('{dc, rdata, 2'b00});
            end else begin
               dc = r + 1 + T;
               m_tmo++;
               exp_done.push_back('{dc, 64'd0, 2'b01});
            end
         end
      end
      busy_from = acc + 1;
      busy_to   = dc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      while (cyc <= dc) begin
         if (!addr[0] && (abort_at >= 0) && (cyc == r + abort_at)) begin
            do_reset();
            return;
         end
         rsp_valid = 1'b0;
         if (cyc == r + stale_at) begin
            rsp_valid = 1'b1; rsp_tid = stale_tid; rsp_data = {$urandom, $urandom};
            m_stale++;
         end
         if (!wr && (cyc == r + rsp_at)) begin
            rsp_valid = 1'b1; rsp_tid = tid; rsp_data = rdata;
            if (!matched) m_stale++;
         end
         @(posedge clk); #1;
      end
      rsp_valid = 1'b0;
   endtask

`ifdef MMIO_REQ_STATS_EN
   task automatic chk_stats();
      chk("stat_rd", stat_rd_cnt, 64'(m_rd));
      chk("stat_wr", stat_wr_cnt, 64'(m_wr));
      chk("stat_tmo", stat_tmo_cnt, 64'(m_tmo));
      chk("stat_stale", stat_stale_cnt, 64'(m_stale));
   endtask
`endif

   initial begin
      int a;
      int saved_done;
      repeat (2) @(posedge clk);
      #1;
      checking = 1'b1;
      chk("rst_addr", mmio_addr, 64'd0);
      chk("rst_tid", mmio_tid, 64'd0);
      chk("rst_wdata", mmio_wdata, 64'd0);
      chk("rst_ready", cmd_ready, 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: write
      run_cmd(1'b1, 16'h0020, 64'hDEADBEEF_CAFEF00D, -1, 9'd0, -1, 64'd0, -1, a);
      chk("t1_tid", last_req_tid, 64'd0);
      chk("t1_req_lat", 64'(last_req_c - a), 64'd1);
      chk("t1_done_lat", 64'(last_done_c - a), 64'd2);
      chk("t1_err", last_done_err, 64'd0);

      // 2: read, response 3 cycles after request
      run_cmd(1'b0, 16'h0020, 64'd0, -1, 9'd0, 3, 64'hDEADBEEF_CAFEF00D, -1, a);
      chk("t2_tid", last_req_tid, 64'd1);
      chk("t2_rdata", last_done_rdata, 64'hDEADBEEF_CAFEF00D);
      chk("t2_lat", 64'(last_done_c - a), 64'd5);

      // 3: stale tid then matching tid
      run_cmd(1'b0, 16'h0000, 64'd0, 1, 9'd5, 2, 64'h0123_4567_89AB_CDEF, -1, a);
      chk("t3_tid", last_req_tid, 64'd2);
      chk("t3_rdata", last_done_rdata, 64'h0123_4567_89AB_CDEF);
      chk("t3_lat", 64'(last_done_c - a), 64'd4);

      // 4: no response -> timeout
      run_cmd(1'b0, 16'h0040, 64'd0, -1, 9'd0, -1, 64'd0, -1, a);
      chk("t4_lat", 64'(last_done_c - a), 64'd18);
      chk("t4_err", last_done_err, 64'd1);
      chk("t4_rdata", last_done_rdata, 64'd0);

      // 5: misaligned
      run_cmd(1'b1, 16'h0021, 64'h55, -1, 9'd0, -1, 64'd0, -1, a);
      chk("t5_lat", 64'(last_done_c - a), 64'd1);
      chk("t5_err", last_done_err, 64'd2);
      chk("t5_noreq", 64'(last_req_c < a), 64'd1);

      // match on the final timer cycle beats the timeout
      run_cmd(1'b0, 16'h0008, 64'd0, -1, 9'd0, T, 64'hA5A5_5A5A_0F0F_F0F0, -1, a);
      chk("tlast_err", last_done_err, 64'd0);
      chk("tlast_rdata", last_done_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
      chk("tlast_tid", last_req_tid, 64'd4);
      // one cycle too late, and a response during ISSUE: both ignored
      run_cmd(1'b0, 16'h0010, 64'd0, -1, 9'd0, T + 1, 64'h1111, -1, a);
      chk("tlate_err", last_done_err, 64'd1);
      run_cmd(1'b0, 16'h0018, 64'd0, -1, 9'd0, 0, 64'h2222, -1, a);
      chk("tissue_err", last_done_err, 64'd1);
      run_cmd(1'b1, 16'h0030, 64'h77, 0, 9'd7, -1, 64'd0, -1, a);
      chk("tstray_tid", last_req_tid, 64'd7);
`ifdef MMIO_REQ_STATS_EN
      chk_stats();
`endif

      // 6: tid wrap over 513 back-to-back writes
      do_reset();
      for (int i = 0; i < 513; i++) begin
         run_cmd(1'b1, 16'(i << 1), {$urandom, $urandom}, -1, 9'd0, -1, 64'd0, -1, a);
         if (i == 511) chk("t6_tid511", last_req_tid, 64'd511);
      end
      chk("t6_wrap_tid", last_req_tid, 64'd0);

      // reset while waiting for a read response; the late response is ignored
      saved_done = last_done_c;
      run_cmd(1'b0, 16'h0100, 64'd0, -1, 9'd0, -1, 64'd0, 4, a);
      rsp_valid = 1'b1; rsp_tid = 9'd1; rsp_data = 64'h3333;
      m_stale++;
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_no_done", 64'(last_done_c), 64'(saved_done));
      run_cmd(1'b1, 16'h0200, 64'hBEEF, -1, 9'd0, -1, 64'd0, -1, a);
      chk("rst_tid0", last_req_tid, 64'd0);
`ifdef MMIO_REQ_STATS_EN
      chk_stats();
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("end_queues", 64'(exp_req.size() + exp_done.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
